mips_bus_arbiter: RTL and testbench

//  Two-master to one-slave arbiter for the CPU memory bus (address/read/write/waitrequest/byteenable).

---
 rtl/mips_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory slave between instruction
// fetch (m0) and data load/store (m1); one transaction in flight at a time.
module mips_bus_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   output logic                grant,
   output logic                busy
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic [2:0]        lat_cnt_q, lat_cnt_d;

   logic [ADDR_W-1:0] cmd_addr_p0, cmd_addr_p1;
   logic [DATA_W-1:0] cmd_wdata_p0, cmd_wdata_p1;
   logic [BE_W-1:0]   cmd_be_p0, cmd_be_p1;
   logic              cmd_rd_p0, cmd_rd_p1;
   logic              cmd_wr_p0, cmd_wr_p1;

   logic              req0, req1, sel, done, rd_done;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      lat_cnt_d    = lat_cnt_q;
      cmd_addr_p0  = cmd_addr_p1;
      cmd_wdata_p0 = cmd_wdata_p1;
      cmd_be_p0    = cmd_be_p1;
      cmd_rd_p0    = cmd_rd_p1;
      cmd_wr_p0    = cmd_wr_p1;
      sel          = grant_q;
      done         = 1'b0;
      rd_done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               // A tie goes to whoever did not own the bus last.
               sel          = (req0 & req1) ? ~grant_q : req1;
               grant_d      = sel;
               cmd_addr_p0  = sel ? m1_address    : m0_address;
               cmd_wdata_p0 = sel ? m1_writedata  : m0_writedata;
               cmd_be_p0    = sel ? m1_byteenable : m0_byteenable;
               cmd_wr_p0    = sel ? m1_write      : m0_write;
               cmd_rd_p0    = ~cmd_wr_p0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (!s_waitrequest) begin
               if (cmd_wr_p1) begin
                  cmd_wr_p0 = 1'b0;
                  done      = 1'b1;
                  state_d   = IDLE;
               end else begin
                  cmd_rd_p0 = 1'b0;
                  lat_cnt_d = LAT_INIT;
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            if (lat_cnt_q != 3'd0) begin
               lat_cnt_d = lat_cnt_q - 3'd1;
            end else begin
               done    = 1'b1;
               rd_done = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered slave command and arbitration state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= 1'b1;
         lat_cnt_q    <= '0;
         cmd_addr_p1  <= '0;
         cmd_wdata_p1 <= '0;
         cmd_be_p1    <= '0;
         cmd_rd_p1    <= 1'b0;
         cmd_wr_p1    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         lat_cnt_q    <= lat_cnt_d;
         cmd_addr_p1  <= cmd_addr_p0;
         cmd_wdata_p1 <= cmd_wdata_p0;
         cmd_be_p1    <= cmd_be_p0;
         cmd_rd_p1    <= cmd_rd_p0;
         cmd_wr_p1    <= cmd_wr_p0;
      end
   end

   assign m0_waitrequest = ~(done & ~grant_q);
   assign m1_waitrequest = ~(done & grant_q);
   assign m0_readdata    = (rd_done & ~grant_q) ? s_readdata : '0;
   assign m1_readdata    = (rd_done & grant_q)  ? s_readdata : '0;

   assign s_address      = cmd_addr_p1;
   assign s_read         = cmd_rd_p1;
   assign s_write        = cmd_wr_p1;
   assign s_writedata    = cmd_wdata_p1;
   assign s_byteenable   = cmd_be_p1;
   assign grant          = grant_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: directed scenarios on a latency-1 and a latency-3
// instance, then randomized two-master traffic against a transaction-level memory model.
module tb_mips_bus_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // latency-1 instance
   logic [31:0] m0_address = '0, m1_address = '0, m0_writedata = '0, m1_writedata = '0;
   logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic [31:0] s_address, s_writedata, s_readdata;
   logic        s_read, s_write, grant, busy;
   logic [3:0]  s_byteenable;
   logic        s_waitrequest = 1'b0;

   // latency-3 instance
   logic [31:0] b_m0_address = '0, b_m1_address = '0, b_m0_writedata = '0, b_m1_writedata = '0;
   logic        b_m0_read = 1'b0, b_m0_write = 1'b0, b_m1_read = 1'b0, b_m1_write = 1'b0;
   logic [3:0]  b_m0_byteenable = '0, b_m1_byteenable = '0;
   logic        b_m0_waitrequest, b_m1_waitrequest;
   logic [31:0] b_m0_readdata, b_m1_readdata;
   logic [31:0] b_s_address, b_s_writedata, b_s_readdata;
   logic        b_s_read, b_s_write, b_grant, b_busy;
   logic [3:0]  b_s_byteenable;
   logic        b_s_waitrequest = 1'b0;

   mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .grant(grant), .busy(busy)
   );

   mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .m0_address(b_m0_address), .m0_read(b_m0_read), .m0_write(b_m0_write),
      .m0_writedata(b_m0_writedata), .m0_byteenable(b_m0_byteenable),
      .m0_waitrequest(b_m0_waitrequest), .m0_readdata(b_m0_readdata),
      .m1_address(b_m1_address), .m1_read(b_m1_read), .m1_write(b_m1_write),
      .m1_writedata(b_m1_writedata), .m1_byteenable(b_m1_byteenable),
      .m1_waitrequest(b_m1_waitrequest), .m1_readdata(b_m1_readdata),
      .s_address(b_s_address), .s_read(b_s_read), .s_write(b_s_write),
      .s_writedata(b_s_writedata), .s_byteenable(b_s_byteenable),
      .s_waitrequest(b_s_waitrequest), .s_readdata(b_s_readdata),
      .grant(b_grant), .busy(b_busy)
   );

   function automatic logic [31:0] init_word(input logic [5:0] k);
      if (k == 6'd0)  return 32'h3C08BFC0;
      if (k == 6'd12) return 32'h11223344;
      return {2'b00, k, 24'h0} ^ 32'h5500AA77 ^ {26'h0, k};
   endfunction

   // Single-port memory slave, fixed read latency 1, junk when no read was accepted.
   logic [31:0] smem [0:63];
   logic [31:0] rd_pipe;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 64; k++) smem[k] <= init_word(6'(k));
         rd_pipe <= 32'hDEADBEEF;
      end else begin
         if (s_write && !s_waitrequest)
            for (int b = 0; b < 4; b++)
               if (s_byteenable[b]) smem[s_address[7:2]][8*b +: 8] <= s_writedata[8*b +: 8];
         rd_pipe <= (s_read && !s_waitrequest) ? smem[s_address[7:2]] : 32'hDEADBEEF;
      end
   end
   assign s_readdata = rd_pipe;

   // Latency-3 slave: data is a fixed function of the accepted address.
   logic [31:0] b_pipe [0:2];
   logic [31:0] b_saw;
   always @(posedge clk) begin
      b_pipe[0] <= (b_s_read && !b_s_waitrequest) ? (b_s_address ^ 32'hC0DE0000) : 32'hDEADBEEF;
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
      if (b_s_read && !b_s_waitrequest) b_saw <= b_s_address;
   end
   assign b_s_readdata = b_pipe[2];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive_m(input int i, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
      if (i == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
      end
   endtask

   // transaction-level reference state for the random phase
   logic [31:0] ref_mem [0:63];
   logic        pend [2];
   logic        rwr [2];
   logic [5:0]  ridx [2];
   logic [31:0] rdat [2];
   logic [3:0]  rbe [2];
   int          age [2];
   int          ocnt [2];
   int          order [8];
   int          n;
   int          cyc;

   initial begin
      // 1: reset values, then reset during a stalled write
      repeat (3) tick();
      mid();
      chk("rst_m0_wait", 128'(m0_waitrequest), 128'(1));
      chk("rst_m1_wait", 128'(m1_waitrequest), 128'(1));
      chk("rst_grant", 128'(grant), 128'(1));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_strobes", 128'({s_read, s_write}), 128'(0));
      chk("rst_s_cmd", 128'({s_address, s_writedata, s_byteenable}), 128'(0));
      chk("rst_rdata", 128'({m0_readdata, m1_readdata}), 128'(0));
      reset_n = 1'b1;
      tick();
      s_waitrequest = 1'b1;
      drive_m(1, 1'b0, 1'b1, 32'hBFC0002C, 32'h12345678, 4'hF);
      tick();
      mid();
      chk("t1_issue_write", 128'({s_write, busy}), 128'(2'b11));
      tick();
      reset_n = 1'b0;
      #1;
      chk("t1_abort_strobe", 128'(s_write), 128'(0));
      chk("t1_abort_wait", 128'({m0_waitrequest, m1_waitrequest}), 128'(2'b11));
      drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      s_waitrequest = 1'b0;
      mid();
      reset_n = 1'b1;
      #1;
      chk("t1_post_grant", 128'(grant), 128'(1));
      chk("t1_post_idle", 128'(busy), 128'(0));

      // 2: m0 read, latency 1
      tick();
      drive_m(0, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF);
      mid();
      chk("t2_c0_sread", 128'({s_read, m0_waitrequest}), 128'(2'b01));
      tick(); mid();
      chk("t2_c1_sread", 128'({s_read, m0_waitrequest, grant}), 128'(3'b110));
      chk("t2_c1_saddr", 128'(s_address), 128'(32'hBFC00000));
      tick(); mid();
      chk("t2_c2_wait", 128'({m0_waitrequest, m1_waitrequest}), 128'(2'b01));
      chk("t2_c2_rdata", 128'(m0_readdata), 128'(32'h3C08BFC0));
      chk("t2_c2_m1_rdata", 128'(m1_readdata), 128'(0));
      tick();
      drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      mid();
      chk("t2_c3_idle", 128'({m0_waitrequest, busy, m0_readdata}), 128'({1'b1, 1'b0, 32'h0}));

      // 3: m1 write, single-cycle completion
      tick();
      drive_m(1, 1'b0, 1'b1, 32'hBFC0002C, 32'hFFFF0000, 4'hF);
      mid();
      chk("t3_c0_wait", 128'(m1_waitrequest), 128'(1));
      tick(); mid();
      chk("t3_c1_done", 128'({m0_waitrequest, m1_waitrequest, s_write}), 128'(3'b101));
      chk("t3_c1_scmd", 128'({s_address, s_writedata, s_byteenable}), 128'({32'hBFC0002C, 32'hFFFF0000, 4'hF}));
      tick();
      drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      mid();
      chk("t3_c2_onecycle", 128'({m1_waitrequest, busy}), 128'(2'b10));
      chk("t3_mem11", 128'(smem[11]), 128'(32'hFFFF0000));

      // 4: both masters request continuously; grants alternate
      tick();
      drive_m(0, 1'b0, 1'b1, 32'hBFC00010, 32'h0000AAAA, 4'hF);
      drive_m(1, 1'b0, 1'b1, 32'hBFC00014, 32'h0000BBBB, 4'hF);
      n = 0;
      cyc = 0;
      while (n < 8 && cyc < 40) begin
         mid();
         if (!m0_waitrequest && n < 8) begin order[n] = 0; n++; end
         if (!m1_waitrequest && n < 8) begin order[n] = 1; n++; end
         tick();
         cyc++;
      end
      drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk("t4_count", 128'(n), 128'(8));
      for (int k = 0; k < 8; k++) chk("t4_alternate", 128'(order[k]), 128'(k % 2));

      // 5: slave stall during m1 write with m0 read pending
      tick();
      s_waitrequest = 1'b1;
      drive_m(1, 1'b0, 1'b1, 32'hBFC00030, 32'hA5A55A5A, 4'b0101);
      mid();
      tick();
      drive_m(0, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF);
      for (int j = 0; j < 5; j++) begin
         mid();
         chk("t5_stall_scmd", 128'({s_address, s_writedata, s_byteenable, s_write}),
             128'({32'hBFC00030, 32'hA5A55A5A, 4'b0101, 1'b1}));
         chk("t5_stall_wait", 128'({m0_waitrequest, m1_waitrequest}), 128'(2'b11));
         tick();
      end
      s_waitrequest = 1'b0;
      mid();
      chk("t5_release_done", 128'({m0_waitrequest, m1_waitrequest}), 128'(2'b10));
      tick();
      drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      mid();
      chk("t5_idle", 128'({m0_waitrequest, busy}), 128'(2'b10));
      tick(); mid();
      chk("t5_m0_issue", 128'({s_read, grant, s_address}), 128'({2'b10, 32'hBFC00000}));
      tick(); mid();
      chk("t5_m0_done", 128'({m0_waitrequest, m0_readdata}), 128'({1'b0, 32'h3C08BFC0}));
      tick();
      drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk("t5_mem12", 128'(smem[12]), 128'(32'h11A5335A));

      // 6: latency 3, m1 address changes after grant
      b_m1_read = 1'b1;
      b_m1_address = 32'h00000040;
      mid();
      chk("t6_c0_wait", 128'(b_m1_waitrequest), 128'(1));
      tick();
      b_m1_address = 32'h00000080;
      mid();
      chk("t6_c1_issue", 128'({b_s_read, b_m1_waitrequest, b_s_address}), 128'({2'b11, 32'h40}));
      tick(); mid();
      chk("t6_c2_wait", 128'(b_m1_waitrequest), 128'(1));
      tick(); mid();
      chk("t6_c3_wait", 128'(b_m1_waitrequest), 128'(1));
      tick(); mid();
      chk("t6_c4_done", 128'({b_m1_waitrequest, b_m0_waitrequest}), 128'(2'b01));
      chk("t6_c4_rdata", 128'(b_m1_readdata), 128'(32'hC0DE0040));
      chk("t6_saw_addr", 128'(b_saw), 128'(32'h40));
      tick();
      b_m1_read = 1'b0;
      mid();
      chk("t6_idle", 128'({b_m1_waitrequest, b_busy, b_m1_readdata}), 128'({2'b10, 32'h0}));

      // random two-master traffic against the reference memory
      tick();
      reset_n = 1'b0;
      drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      mid();
      reset_n = 1'b1;
      for (int k = 0; k < 64; k++) ref_mem[k] = init_word(6'(k));
      for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; age[i] = 0; ocnt[i] = 0; end
      for (int c = 0; c < 600; c++) begin
         tick();
         s_waitrequest = ($urandom_range(3) == 0);
         for (int i = 0; i < 2; i++) begin
            if (pend[i]) begin
               age[i]++;
            end else if ($urandom_range(2) == 0) begin
               pend[i] = 1'b1; age[i] = 0; ocnt[i] = 0;
               ridx[i] = 6'($urandom_range(15));
               rwr[i]  = 1'($urandom_range(1));
               rdat[i] = $urandom;
               rbe[i]  = 4'($urandom);
               drive_m(i, rwr[i] ? 1'($urandom_range(1)) : 1'b1, rwr[i],
                       32'hBFC00000 | {24'h0, ridx[i], 2'b00}, rdat[i], rbe[i]);
            end else begin
               drive_m(i, 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
            end
         end
         mid();
         chk("rnd_one_owner", 128'(m0_waitrequest | m1_waitrequest), 128'(1));
         for (int i = 0; i < 2; i++) begin
            logic        w;
            logic [31:0] rd;
            w  = (i == 0) ? m0_waitrequest : m1_waitrequest;
            rd = (i == 0) ? m0_readdata : m1_readdata;
            if (w) begin
               chk("rnd_rdata_idle", 128'(rd), 128'(0));
            end else begin
               chk("rnd_owner_pending", 128'(pend[i]), 128'(1));
               if (pend[i]) begin
                  if (rwr[i]) begin
                     for (int b = 0; b < 4; b++)
                        if (rbe[i][b]) ref_mem[ridx[i]][8*b +: 8] = rdat[i][8*b +: 8];
                  end else begin
                     chk("rnd_rdata", 128'(rd), 128'(ref_mem[ridx[i]]));
                  end
                  chk("rnd_fair", 128'(ocnt[i] <= 1), 128'(1));
                  chk("rnd_latency", 128'(age[i] < 60), 128'(1));
                  pend[i] = 1'b0;
                  if (pend[1-i]) ocnt[1-i]++;
               end
            end
         end
      end
      for (int i = 0; i < 2; i++) chk("rnd_no_starve", 128'(!pend[i] || age[i] < 60), 128'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
